// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcode constants, instruction formats and NOP word
package rv_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_t;

    // shift-immediates share OP_IMM but carry funct7 and a 5-bit shamt
    function automatic fmt_t op_fmt(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_R:             return FMT_R;
            OP_IMM:           return (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
            OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:         return FMT_S;
            OP_BRANCH:        return FMT_B;
            OP_LUI, OP_AUIPC: return FMT_U;
            OP_JAL:           return FMT_J;
            default:          return FMT_BAD;
        endcase
    endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field packer with immediate range/alignment check
module instr_pack
    import rv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);
    fmt_t fmt;
    assign fmt = op_fmt(opcode, funct3);

    // pack fields by format; an immediate fits when its upper bits are pure sign extension
    always_comb begin
        word  = 32'h0;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                word  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            FMT_I: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = &imm[31:11] | ~|imm[31:11];
            end
            FMT_SH: begin
                word  = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                legal = ~|imm[31:5];
            end
            FMT_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = &imm[31:11] | ~|imm[31:11];
            end
            FMT_B: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = (&imm[31:12] | ~|imm[31:12]) & ~imm[0];
            end
            FMT_U: begin
                word  = {imm[31:12], rd, opcode};
                legal = ~|imm[11:0];
            end
            FMT_J: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = (&imm[31:20] | ~|imm[31:20]) & ~imm[0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder with 2-entry output buffer and saturating counters
module instr_encoder
    import rv_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = NOP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] acc_count,
    output logic [CNT_W-1:0] err_count
);
    logic [31:0] word;
    logic        legal;
    logic [32:0] mem [2];
    logic        wp, rp, rdy, push, pop;
    logic [1:0]  cnt, cnt_nxt;

    instr_pack u_pack (
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (word),
        .legal  (legal)
    );

    assign in_ready  = rdy;
    assign out_valid = cnt != 2'd0;
    assign out_err   = mem[rp][32];
    assign out_instr = mem[rp][31:0];
    assign push      = in_valid && rdy;
    assign pop       = out_valid && out_ready;
    assign cnt_nxt   = cnt + 2'(push) - 2'(pop);

    // buffer, pointers, registered ready and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem       <= '{default: '0};
            wp        <= 1'b0;
            rp        <= 1'b0;
            cnt       <= 2'd0;
            rdy       <= 1'b0;
            acc_count <= '0;
            err_count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= {~legal, legal ? word : NOP_WORD};
                wp      <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            cnt <= cnt_nxt;
            rdy <= cnt_nxt < 2'd2;
            if (push && acc_count != '1)
                acc_count <= acc_count + CNT_W'(1);
            if (push && !legal && err_count != '1)
                err_count <= err_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench with directed, backpressure, random round-trip and reset steps
module tb_instr_encoder;
    import rv_pkg::*;

    localparam int CW = 4;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
        bit          rt;
    } req_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_err;
    logic [6:0] in_opcode = '0, in_funct7 = '0;
    logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0] in_funct3 = '0;
    logic [31:0] in_imm = '0, out_instr;
    logic [CW-1:0] acc_count, err_count;

    int errors = 0, checks = 0, ncyc = 0, n_acc = 0, n_err = 0;
    req_t sb[$];
    req_t cur;

    instr_encoder #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
        .acc_count(acc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dec_imm(input logic [31:0] w);
        case (w[6:0])
            OP_LOAD, OP_JALR: return {{20{w[31]}}, w[31:20]};
            OP_IMM:           return (w[14:12] == 3'b001 || w[14:12] == 3'b101) ? {27'b0, w[24:20]} : {{20{w[31]}}, w[31:20]};
            OP_STORE:         return {{20{w[31]}}, w[31:25], w[11:7]};
            OP_BRANCH:        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            OP_LUI, OP_AUIPC: return {w[31:12], 12'b0};
            OP_JAL:           return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:          return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic req_t mk(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] word, input logic err, input bit rt);
        req_t r;
        r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7;
        r.imm = imm; r.word = word; r.err = err; r.rt = rt;
        return r;
    endfunction

    function automatic int sat(input int n);
        return n > (2**CW - 1) ? 2**CW - 1 : n;
    endfunction

    task automatic cyc();
        req_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0)
                chk("unexpected_word", out_instr, 32'hxxxx_xxxx);
            else begin
                e = sb.pop_front();
                if (e.rt) begin
                    chk("rt_imm", dec_imm(out_instr), e.imm);
                    chk("rt_op_rd", {20'b0, out_instr[11:0]}, {20'b0, (e.op == OP_STORE || e.op == OP_BRANCH) ? out_instr[11:7] : e.rd, e.op});
                    chk("rt_err", {31'b0, out_err}, 32'd0);
                end else begin
                    chk("word", out_instr, e.word);
                    chk("err", {31'b0, out_err}, {31'b0, e.err});
                end
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back(cur);
            n_acc++;
            if (cur.err) n_err++;
        end
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic drive(input req_t r);
        cur = r;
        in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
        in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm;
        in_valid = 1'b1;
    endtask

    task automatic send(input req_t r);
        logic a;
        drive(r);
        for (int i = 0; i < 50; i++) begin
            a = in_ready;
            cyc();
            if (a) begin
                in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++)
            cyc();
        chk("drain_left", sb.size(), 32'd0);
    endtask

    initial begin
        req_t r;
        logic [31:0] u, held;
        int k, t0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {31'b0, out_err}, 32'd0);
        chk("rst_acc", {28'b0, acc_count}, 32'd0);
        chk("rst_errc", {28'b0, err_count}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // directed encodings, one word at a time with latency check
        out_ready = 1'b0;
        send(mk(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0, 0));
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_instr", out_instr, 32'h00500093);
        chk("acc_one", {28'b0, acc_count}, 32'd1);
        out_ready = 1'b1;
        drain();
        send(mk(OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020A423, 1'b0, 0));
        send(mk(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h1234_5678, 32'h002081B3, 1'b0, 0));
        send(mk(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0, 0));
        send(mk(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFFDFF0EF, 1'b0, 0));
        send(mk(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8, 32'hFE208CE3, 1'b0, 0));
        send(mk(OP_IMM, 5'd2, 5'd3, 5'd0, 3'b101, 7'b0100000, 32'd31, 32'h41F1D113, 1'b0, 0));
        drain();
        send(mk(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, NOP, 1'b1, 0));
        drain();
        chk("errc_one", {28'b0, err_count}, 32'd1);
        send(mk(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, NOP, 1'b1, 0));
        send(mk(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h80000093, 1'b0, 0));
        send(mk(OP_IMM, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32, NOP, 1'b1, 0));
        send(mk(OP_AUIPC, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, NOP, 1'b1, 0));
        send(mk(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, NOP, 1'b1, 0));
        send(mk(7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, NOP, 1'b1, 0));
        drain();
        chk("acc_mid", {28'b0, acc_count}, sat(n_acc));
        chk("errc_mid", {28'b0, err_count}, sat(n_err));

        // backpressure: two accepts fill the buffer, third is held, then all drain in order
        out_ready = 1'b0;
        send(mk(OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100393, 1'b0, 0));
        send(mk(OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00200393, 1'b0, 0));
        drive(mk(OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00300393, 1'b0, 0));
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        held = out_instr;
        cyc();
        chk("stall_hold", out_instr, held);
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        send(cur);
        drain();

        // streaming random legal requests with round-trip decode
        t0 = ncyc;
        for (int i = 0; i < 100; i++) begin
            u = $urandom;
            k = $urandom_range(0, 5);
            r = mk(OP_IMM, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 32'd0, 32'd0, 1'b0, 1);
            case (k)
                0: begin r.f3 = 3'b000; r.imm = {{20{u[11]}}, u[11:0]}; end
                1: begin r.op = OP_STORE; r.imm = {{20{u[11]}}, u[11:0]}; end
                2: begin r.op = OP_BRANCH; r.imm = {{19{u[12]}}, u[12:1], 1'b0}; end
                3: begin r.op = u[0] ? OP_LUI : OP_AUIPC; r.imm = {u[31:12], 12'b0}; end
                4: begin r.op = OP_JAL; r.imm = {{11{u[20]}}, u[20:1], 1'b0}; end
                default: begin r.f3 = u[5] ? 3'b001 : 3'b101; r.imm = {27'b0, u[4:0]}; end
            endcase
            send(r);
        end
        chk("throughput_cycles", ncyc - t0, 32'd100);
        drain();

        // error counter saturation
        for (int i = 0; i < 17; i++)
            send(mk(7'b0000000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, NOP, 1'b1, 0));
        drain();
        chk("acc_sat", {28'b0, acc_count}, sat(n_acc));
        chk("errc_sat", {28'b0, err_count}, sat(n_err));

        // reset with two words buffered
        out_ready = 1'b0;
        send(mk(OP_IMM, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 32'h00900493, 1'b0, 0));
        send(mk(OP_IMM, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h00800493, 1'b0, 0));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("mid_rst_acc", {28'b0, acc_count}, 32'd0);
        chk("mid_rst_errc", {28'b0, err_count}, 32'd0);
        sb.delete();
        n_acc = 0;
        n_err = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) cyc();
        chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_ready2", {31'b0, in_ready}, 32'd1);
        send(mk(OP_IMM, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h00400213, 1'b0, 0));
        drain();
        chk("post_rst_acc", {28'b0, acc_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end
endmodule
